sqrt_share_arbiter: RTL and testbench
=====================================

Name: sqrt_share_arbiter

Overview:
- Shares one iterative integer square-root core among NREQ requesters.
- Arbitrates round-robin and runs the core's level handshake on behalf of the granted requester.
- Returns the core's result to that requester and keeps a completed-operation count.
- Sits between the CPU/accelerator request ports and the single square-root core instance.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DW, 32: operand/result width.
- CNTW, 16: width of the completed-operation counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester request level
- req_wdata  in  NREQ*DW  per-requester operand; slot i is bits [i*DW +: DW]
- req_ready  out  NREQ  per-requester completion level
- req_rdata  out  DW  result, shared by all requesters; valid while the corresponding req_ready bit is high
- core_valid  out  1  request level to the core
- core_wdata  out  DW  operand to the core
- core_ready  in  1  core completion level
- core_rdata  in  DW  core result
- busy  out  1  high whenever state is not IDLE
- grant_id  out  $clog2(NREQ)  current/last granted requester
- ops_done  out  CNTW  saturating count of completed operations

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, req_rdata=0, core_valid=0, core_wdata=0, busy=0, grant_id=NREQ-1 (so requester 0 wins first), ops_done=0, state=IDLE.
- An asynchronous reset mid-operation aborts immediately. The core shares resetn, so no residue remains.

Requester protocol:
- Hold req_valid[i] and req_wdata[i] stable until req_ready[i] is seen high.
- Then drop req_valid[i].
- req_ready[i] stays high until req_valid[i] is sampled low, then falls on the next edge.

Core protocol:
- core_valid is held high with stable core_wdata until core_ready=1.
- core_valid then goes low.
- core_ready goes low one cycle after it sees core_valid low.
- The core must observe core_valid low before a new operation starts.

States:
- IDLE: if any req_valid bit is set, pick the first set bit scanning from grant_id+1 upward with wrap-around modulo NREQ. At that edge: register grant_id, core_wdata=req_wdata[grant], core_valid=1, busy=1, and move to ISSUE. With no requests, stay in IDLE.
- ISSUE: wait for core_ready=1. At that edge: capture req_rdata=core_rdata, core_valid=0, move to DRAIN.
- DRAIN: wait for core_ready=0. At that edge: req_ready[grant_id]=1, increment ops_done (saturating at all-ones), move to RESP.
- RESP: while req_valid[grant_id]=1, hold req_ready. When it is sampled 0: req_ready=0, busy=0, move to IDLE.

Arbitration and timing:
- Minimum spacing between grants is one IDLE cycle.
- Requests from other requesters are ignored and left pending while not IDLE.
- A requester that drops req_valid before completion (protocol violation): the operation still completes, req_ready pulses for exactly one cycle, and the result is discarded by the requester.
- A single active requester is re-granted on every arbitration (the wrap includes itself).
- Fixed overhead: 1 cycle request-to-core_valid, plus the core latency, plus 1 cycle DRAIN, plus 1 cycle to req_ready.
- ops_done does not wrap.

Decomposition:
- Shared package sqrt_arb_pkg:
  - state enum (IDLE, ISSUE, DRAIN, RESP);
  - constants DW_DEF=32, NREQ_DEF=4;
  - function next_rr(req, last) returning the round-robin winner index.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (req vector + last index -> winner index + any flag). It is reusable by other shared-core arbiters in the codebase.
- The FSM, data registers and counter stay in sqrt_share_arbiter.

Test Plan:
- Single request: requester 0 requests 144 -> core_wdata=144, req_ready[0] high with req_rdata=12, ops_done=1, grant_id=0.
- Simultaneous requests: requesters 0..3 request 0, 1, 0xFFFFFFFF, 1000000 in the same cycle -> grants in order 0, 1, 2, 3 with results 0, 1, 65535, 1000 respectively, ops_done=4, never two core_valid operations overlapping.
- Fairness wrap: after requester 2 is served, requesters 1 and 3 both request -> requester 3 is granted first, then requester 1.
- Late valid drop: requester 1 holds req_valid 5 cycles after req_ready -> req_ready[1] stays high for 5 cycles and no new grant occurs until the cycle after release. A requester dropping early gets a 1-cycle req_ready pulse.
- Reset mid-ISSUE: assert resetn=0 asynchronously while busy -> all outputs return to reset values without a clock edge. After release, requester 0 requesting 81 returns 9.
- Saturation: with CNTW=4, run 17 back-to-back operations -> ops_done stops at 15.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared types, defaults and the round-robin helper used by shared-core arbiters.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DW_DEF   = 32;
  localparam int NREQ_DEF = 4;
  localparam int RR_MAX   = 8;

  // Round-robin winner among the first n bits of req, searching from last+1
  // upward with wrap-around. last itself has the lowest priority, so a lone
  // requester is re-granted. Returns last when nothing is requested.
  function automatic logic [2:0] next_rr(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        last,
                                         input int                n);
    logic [2:0] win;
    int         idx;
    win = last;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (req[idx[2:0]]) win = idx[2:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sqrt_share_arbiter_rr_pick.sv
// Combinational round-robin priority picker: request vector + last winner
// in, next winner + any-request flag out.
module rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [RR_MAX-1:0] req_ext;
  logic [2:0]        last_ext;
  logic [2:0]        win_ext;

  // Widen the request vector to the helper's fixed width.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

  assign last_ext = 3'(last);
  assign win_ext  = next_rr(req_ext, last_ext, NREQ);
  assign winner   = IW'(win_ext);
  assign any      = |req;

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Shares one iterative square-root core among NREQ requesters: round-robin
// grant, level handshake toward the core, result return and a saturating
// completed-operation counter. All outputs come straight from flops.
module sqrt_share_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int CNTW = 16,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [DW-1:0]    req_rdata,
  output logic             core_valid,
  output logic [DW-1:0]    core_wdata,
  input  logic             core_ready,
  input  logic [DW-1:0]    core_rdata,
  output logic             busy,
  output logic [IW-1:0]    grant_id,
  output logic [CNTW-1:0]  ops_done
);

  arb_state_t      state, state_d;
  logic [IW-1:0]   grant_d;
  logic [NREQ-1:0] req_ready_d;
  logic [DW-1:0]   req_rdata_d;
  logic            core_valid_d;
  logic [DW-1:0]   core_wdata_d;
  logic            busy_d;
  logic [CNTW-1:0] ops_done_d;

  logic [IW-1:0]   pick_id;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_valid),
    .last   (grant_id),
    .winner (pick_id),
    .any    (pick_any)
  );

  // Next state and next output values; everything holds unless a transition fires.
  always_comb begin
    state_d      = state;
    grant_d      = grant_id;
    req_ready_d  = req_ready;
    req_rdata_d  = req_rdata;
    core_valid_d = core_valid;
    core_wdata_d = core_wdata;
    busy_d       = busy;
    ops_done_d   = ops_done;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_id;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_id == IW'(i)) core_wdata_d = req_wdata[i*DW +: DW];
          end
          core_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (core_ready) begin
          req_rdata_d  = core_rdata;
          core_valid_d = 1'b0;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the core to see core_valid low before completing, so the
        // next operation cannot be mistaken for the tail of this one.
        if (!core_ready) begin
          req_ready_d[grant_id] = 1'b1;
          ops_done_d            = (&ops_done) ? ops_done : ops_done + CNTW'(1);
          state_d               = RESP;
        end
      end
      RESP: begin
        if (!req_valid[grant_id]) begin
          req_ready_d = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_id   <= IW'(NREQ - 1);
      req_ready  <= '0;
      req_rdata  <= '0;
      core_valid <= 1'b0;
      core_wdata <= '0;
      busy       <= 1'b0;
      ops_done   <= '0;
    end else begin
      state      <= state_d;
      grant_id   <= grant_d;
      req_ready  <= req_ready_d;
      req_rdata  <= req_rdata_d;
      core_valid <= core_valid_d;
      core_wdata <= core_wdata_d;
      busy       <= busy_d;
      ops_done   <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Bench for sqrt_share_arbiter: behavioural square-root core, requester
// stimulus and a transaction-level round-robin/result reference model.
module tb_sqrt_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CNTW = 4;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     req_rdata;
  logic              core_valid;
  logic [DW-1:0]     core_wdata;
  logic              core_ready;
  logic [DW-1:0]     core_rdata;
  logic              busy;
  logic [IW-1:0]     grant_id;
  logic [CNTW-1:0]   ops_done;

  int checks = 0;
  int failures = 0;

  sqrt_share_arbiter #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .req_rdata  (req_rdata),
    .core_valid (core_valid),
    .core_wdata (core_wdata),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .busy       (busy),
    .grant_id   (grant_id),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural core with programmable latency.
  int   core_lat = 2;
  int   lat_cnt;
  int   proto_err = 0;
  logic cv_prev;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_ready <= 1'b0;
      core_rdata <= '0;
      lat_cnt    <= 0;
      cv_prev    <= 1'b0;
    end else begin
      cv_prev <= core_valid;
      if (core_valid && !cv_prev && core_ready) proto_err <= proto_err + 1;
      if (core_valid && !core_ready) begin
        if (lat_cnt >= core_lat) begin
          core_ready <= 1'b1;
          core_rdata <= DW'(isqrt(64'(core_wdata)));
          lat_cnt    <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else if (!core_valid && core_ready) begin
        core_ready <= 1'b0;
      end
    end
  end

  // Reference model state.
  logic [NREQ-1:0] pending = '0;
  logic [DW-1:0]   opnd [NREQ];
  int              last_g = NREQ - 1;
  int              ops_m = 0;

  function automatic int model_pick(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input int id, input logic [DW-1:0] val);
    req_valid[id] = 1'b1;
    req_wdata[id*DW +: DW] = val;
    opnd[id] = val;
    pending[id] = 1'b1;
  endtask

  task automatic model_done(input int id);
    if (ops_m < (1 << CNTW) - 1) ops_m++;
    last_g = id;
    pending[id] = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    req_wdata = '0;
    pending = '0;
    last_g = NREQ - 1;
    ops_m = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rdata"}, 64'(req_rdata), 64'd0);
    chk({tag, "_cvalid"}, 64'(core_valid), 64'd0);
    chk({tag, "_cwdata"}, 64'(core_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant"}, 64'(grant_id), 64'(NREQ - 1));
    chk({tag, "_ops"}, 64'(ops_done), 64'd0);
  endtask

  // Serve the requester the model predicts; optionally hold valid after
  // completion and optionally raise another request while in the response.
  task automatic serve_next(input int want, input int hold, input int extra);
    int   id;
    int   cyc;
    logic seen;
    id = model_pick(pending, last_g);
    cyc = 0;
    seen = 1'b0;
    while (!(|req_ready) && cyc < 300) begin
      if (core_valid && !seen) begin
        seen = 1'b1;
        chk("issue_wdata", 64'(core_wdata), 64'(opnd[id]));
        chk("issue_grant", 64'(grant_id), 64'(id));
        chk("issue_busy", 64'(busy), 64'd1);
      end
      @(negedge clk);
      cyc++;
    end
    chk("ready_timeout", 64'(cyc < 300), 64'd1);
    chk("issue_seen", 64'(seen), 64'd1);
    model_done(id);
    chk("ready_onehot", 64'(req_ready), 64'(1 << id));
    chk("result", 64'(req_rdata), isqrt(64'(opnd[id])));
    chk("grant", 64'(grant_id), 64'(id));
    if (want >= 0) chk("grant_order", 64'(grant_id), 64'(want));
    chk("ops_done", 64'(ops_done), 64'(ops_m));
    if (extra >= 0) request(extra, DW'($urandom));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("ready_hold", 64'(req_ready), 64'(1 << id));
      chk("no_grant_hold", 64'(core_valid), 64'd0);
    end
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("ready_fall", 64'(req_ready), 64'd0);
    chk("busy_fall", 64'(busy), 64'd0);
    chk("idle_gap", 64'(core_valid), 64'd0);
    if (extra >= 0) begin
      @(negedge clk);
      chk("regrant_valid", 64'(core_valid), 64'd1);
      chk("regrant_id", 64'(grant_id), 64'(extra));
    end
  endtask

  task automatic wait_core_valid(input string tag);
    int cyc;
    cyc = 0;
    while (!core_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 64'(cyc < 50), 64'd1);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < NREQ; i++) opnd[i] = '0;

    // Reset state.
    do_reset();
    chk_reset_outputs("rst");

    // Single request: sqrt(144) = 12.
    core_lat = 3;
    request(0, 32'd144);
    serve_next(0, 0, -1);
    chk("single_result", 64'(req_rdata), 64'd12);

    // Simultaneous requests from a fresh reset: grants 0,1,2,3.
    do_reset();
    request(0, 32'd0);
    request(1, 32'd1);
    request(2, 32'hFFFF_FFFF);
    request(3, 32'd1000000);
    serve_next(0, 0, -1);
    chk("sim0", 64'(req_rdata), 64'd0);
    serve_next(1, 1, -1);
    chk("sim1", 64'(req_rdata), 64'd1);
    serve_next(2, 0, -1);
    chk("sim2", 64'(req_rdata), 64'd65535);
    serve_next(3, 2, -1);
    chk("sim3", 64'(req_rdata), 64'd1000);
    chk("sim_ops", 64'(ops_done), 64'd4);

    // Fairness wrap: after 2 is served, 3 beats 1.
    core_lat = 0;
    request(2, 32'd49);
    serve_next(2, 0, -1);
    request(1, 32'd121);
    request(3, 32'd400);
    serve_next(3, 0, -1);
    serve_next(1, 0, -1);

    // Late drop: requester 1 holds valid 5 cycles; requester 2 waits it out.
    core_lat = 1;
    request(1, 32'd625);
    serve_next(1, 5, 2);
    serve_next(2, 0, -1);

    // Early drop: valid released while the core is working -> 1-cycle ready.
    core_lat = 4;
    request(3, 32'd10000);
    wait_core_valid("early_issue_timeout");
    req_valid[3] = 1'b0;
    cyc = 0;
    while (!(|req_ready) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("early_ready_timeout", 64'(cyc < 100), 64'd1);
    model_done(3);
    chk("early_ready", 64'(req_ready), 64'b1000);
    chk("early_result", 64'(req_rdata), 64'd100);
    @(negedge clk);
    chk("early_pulse", 64'(req_ready), 64'd0);
    chk("early_busy", 64'(busy), 64'd0);

    // Asynchronous reset while the core is busy.
    core_lat = 30;
    request(0, 32'd81);
    wait_core_valid("rst_issue_timeout");
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    req_valid = '0;
    pending = '0;
    last_g = NREQ - 1;
    ops_m = 0;
    @(negedge clk);
    resetn = 1'b1;
    core_lat = 2;
    @(negedge clk);
    request(0, 32'd81);
    serve_next(0, 0, -1);
    chk("post_rst_result", 64'(req_rdata), 64'd9);
    chk("post_rst_ops", 64'(ops_done), 64'd1);

    // Randomised back-to-back operations driving the counter into saturation.
    for (int n = 0; n < 17; n++) begin
      core_lat = int'($urandom_range(0, 4));
      request(int'($urandom_range(0, NREQ - 1)), DW'($urandom));
      serve_next(-1, int'($urandom_range(0, 2)), -1);
    end
    chk("sat_ops", 64'(ops_done), 64'd15);
    chk("core_overlap", 64'(proto_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
